manual_drive_ctrl: RTL and testbench
====================================

// Module: manual_drive_ctrl
// PURPOSE
//  Parametrised manual-driving FSM for the simulated car. Adds brake, reverse gear,
//  stall detection and a cycle-exact power-on hold to the existing power/start/move
//  flow. Drives the 8-bit UART command byte and the 4-bit state LEDs.
//  Sits between debounced board switches and uart_top.
// PARAMETERS
//  POWER_ON_HOLD_CYC  100_000_000  cycles power_on_signal must stay high to leave POWER_OFF
//  IDLE_TIMEOUT_CYC   500_000_000  idle cycles before auto power-off (IDLE_TIMEOUT_EN only)
//  CNT_W              32           counter width; must hold both cycle counts above
// PORTS
//  sys_clk                 in   1  system clock (100 MHz)
//  rst_n                   in   1  asynchronous active-low reset
//  power_on_signal         in   1  power-on request; level, must be held
//  power_off_signal        in   1  power-off request; level
//  manual_driving_signal   in   1  enter manual mode from POWER_ON
//  throttle_signal         in   1  throttle pedal
//  clutch_signal           in   1  clutch pedal
//  brake_signal            in   1  brake pedal
//  reverse_signal          in   1  gear select: 1 = reverse, 0 = forward
//  turn_left_signal        in   1  turn left request
//  turn_right_signal       in   1  turn right request
//  place_barrier_signal    in   1  place barrier request
//  destroy_barrier_signal  in   1  destroy barrier request
//  cmd_byte                out  8  {2'b10,destroy,place,right,left,backward,forward}
//  state_led               out  4  current state encoding
// BEHAVIOUR
//  Inputs are synchronised/debounced upstream. All outputs are registered.
//  Reset: state=POWER_OFF, cmd_byte=8'h80, state_led=4'h0, all counters 0.
//  States: POWER_OFF=0, POWER_ON=1, NOT_STARTING=2, STARTING=3, MOVING=4.
//  Unused encodings 5..15 go to POWER_OFF next cycle.
//  POWER_OFF: hold counter increments while power_on_signal=1 and clears when it is 0.
//   When the counter reaches POWER_ON_HOLD_CYC-1 with the input still high, go to POWER_ON.
//   The counter clears on every exit from POWER_OFF.
//  In any state except POWER_OFF, power_off_signal=1 goes to POWER_OFF; highest priority.
//  POWER_ON: manual_driving_signal=1 goes to NOT_STARTING.
//  NOT_STARTING: throttle & clutch -> STARTING. throttle & ~clutch -> POWER_OFF (stall).
//  STARTING: throttle & ~clutch & ~brake -> MOVING. On this edge, dir_rev <= reverse_signal.
//  MOVING exits, in this priority order:
//   1. reverse_signal != dir_rev & ~clutch -> POWER_OFF (gear grind).
//   2. brake | clutch | ~throttle -> STARTING.
//  cmd_byte[7:6] is always 2'b10. cmd_byte is computed from next_state and the current
//   inputs, so it changes on the same edge as state (one-cycle input latency).
//  cmd_byte[5:0] is 0 in every state except MOVING.
//  In MOVING: forward=~dir_rev, backward=dir_rev.
//   left/right/place/destroy pass their inputs through.
//   If left and right are both 1, both are forced to 0.
//  state_led = state, updated on the same edge as state.
// CONFIGURATION
//  IDLE_TIMEOUT_EN defined:
//   - An idle counter runs in POWER_ON, NOT_STARTING and STARTING.
//   - It clears on any input change and on every state change.
//   - At IDLE_TIMEOUT_CYC-1 the FSM goes to POWER_OFF.
//   - MOVING never times out.
//  IDLE_TIMEOUT_EN undefined: no idle counter and no timeout path.
//   IDLE_TIMEOUT_CYC is ignored.
// STRUCTURE
//  drive_pkg holds:
//   - state localparams (POWER_OFF..MOVING), 4 bits wide
//   - CMD_HDR = 2'b10
//   - cmd bit indices: FWD=0, BWD=1, LEFT=2, RIGHT=3, PLACE=4, DESTROY=5
//  Sub-module hold_counter (CNT_W, TARGET):
//   - ports: sys_clk, rst_n, en, clr, done
//   - done is a 1-cycle pulse at TARGET-1
//   - used for the power-on hold and for the idle timeout
// TESTING
//  Run with POWER_ON_HOLD_CYC=10 and IDLE_TIMEOUT_CYC=20.
//  1. power_on high 9 cycles then low -> stays POWER_OFF.
//     Held 10 cycles -> state_led=1 on cycle 10.
//  2. POWER_ON, manual, then throttle+clutch -> 3. Release clutch -> 4, cmd_byte=8'h81.
//     Then brake=1 -> 3, cmd_byte=8'h80.
//  3. In NOT_STARTING, throttle=1, clutch=0 -> POWER_OFF, cmd_byte=8'h80.
//  4. reverse=1 entering MOVING -> 8'h82. Toggle reverse with clutch=0 -> POWER_OFF.
//     left+right together while MOVING -> bits [3:2]=00.
//  5. rst_n low mid-MOVING -> state=0 and cmd_byte=8'h80 asynchronously.
//     Release -> power_on hold restarts from 0.
//  6. IDLE_TIMEOUT_EN: no input change for 20 cycles in POWER_ON -> POWER_OFF.
//     Without the macro -> stays in POWER_ON.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared state encodings, command-byte layout and input snapshot type for the manual drive controller.
package drive_pkg;

  localparam int unsigned ST_W  = 4;
  localparam int unsigned CMD_W = 8;

  localparam logic [ST_W-1:0] POWER_OFF    = 4'd0;
  localparam logic [ST_W-1:0] POWER_ON     = 4'd1;
  localparam logic [ST_W-1:0] NOT_STARTING = 4'd2;
  localparam logic [ST_W-1:0] STARTING     = 4'd3;
  localparam logic [ST_W-1:0] MOVING       = 4'd4;

  localparam logic [1:0] CMD_HDR = 2'b10;

  localparam int unsigned FWD     = 0;
  localparam int unsigned BWD     = 1;
  localparam int unsigned LEFT    = 2;
  localparam int unsigned RIGHT   = 3;
  localparam int unsigned PLACE   = 4;
  localparam int unsigned DESTROY = 5;

  // Snapshot of every switch input; used to detect "any input changed".
  typedef struct packed {
    logic power_on;
    logic power_off;
    logic manual_driving;
    logic throttle;
    logic clutch;
    logic brake;
    logic reverse;
    logic turn_left;
    logic turn_right;
    logic place_barrier;
    logic destroy_barrier;
  } drive_in_t;

  // True when a counter of width w can reach value v.
  function automatic bit cnt_fits(input int unsigned w, input longint unsigned v);
    return (w >= 64) || (v <= ((64'd1 << w) - 64'd1));
  endfunction

endpackage

// File: rtl/manual_drive_ctrl_if.sv
// Switch inputs and UART/LED outputs of the manual drive controller.
interface manual_drive_ctrl_if;

  logic       power_on_signal;
  logic       power_off_signal;
  logic       manual_driving_signal;
  logic       throttle_signal;
  logic       clutch_signal;
  logic       brake_signal;
  logic       reverse_signal;
  logic       turn_left_signal;
  logic       turn_right_signal;
  logic       place_barrier_signal;
  logic       destroy_barrier_signal;
  logic [7:0] cmd_byte;
  logic [3:0] state_led;

  modport master (
    output power_on_signal, power_off_signal, manual_driving_signal,
           throttle_signal, clutch_signal, brake_signal, reverse_signal,
           turn_left_signal, turn_right_signal, place_barrier_signal,
           destroy_barrier_signal,
    input  cmd_byte, state_led
  );

  modport slave (
    input  power_on_signal, power_off_signal, manual_driving_signal,
           throttle_signal, clutch_signal, brake_signal, reverse_signal,
           turn_left_signal, turn_right_signal, place_barrier_signal,
           destroy_barrier_signal,
    output cmd_byte, state_led
  );

endinterface

// File: rtl/hold_counter.sv
// Cycle counter that pulses done on the cycle it has counted TARGET consecutive enabled cycles.
module hold_counter #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned TARGET = 100_000_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TARGET - 1);

  logic [CNT_W-1:0] cnt;

  // Combinational so the owner can act on the exact TARGET-th cycle.
  assign done = en & ~clr & (cnt == LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Manual-driving FSM: power-on hold, start/move flow, stall and gear-grind power-off, UART command byte.
// Optional feature: define IDLE_TIMEOUT_EN to power off after IDLE_TIMEOUT_CYC idle cycles.
module manual_drive_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned POWER_ON_HOLD_CYC = 100_000_000,
  parameter int unsigned IDLE_TIMEOUT_CYC  = 500_000_000,
  parameter int unsigned CNT_W             = 32
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  manual_drive_ctrl_if.slave drv
);

  localparam bit CFG_OK = cnt_fits(CNT_W, longint'(POWER_ON_HOLD_CYC)) &&
                          cnt_fits(CNT_W, longint'(IDLE_TIMEOUT_CYC));

  if (!CFG_OK) begin : g_cfg_err
    $error("manual_drive_ctrl: CNT_W too narrow for configured cycle counts");
  end

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  next_state;
  logic             dir_rev;
  logic             dir_next;
  logic [CMD_W-1:0] cmd_next;
  logic             hold_done;
  logic             idle_done;

  hold_counter #(.CNT_W(CNT_W), .TARGET(POWER_ON_HOLD_CYC)) u_hold (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en      ((state == POWER_OFF) && drv.power_on_signal),
    .clr     (state != POWER_OFF),
    .done    (hold_done)
  );

`ifdef IDLE_TIMEOUT_EN
  drive_in_t       in_now;
  drive_in_t       in_q;
  logic [ST_W-1:0] state_q;

  assign in_now = '{
    power_on:        drv.power_on_signal,
    power_off:       drv.power_off_signal,
    manual_driving:  drv.manual_driving_signal,
    throttle:        drv.throttle_signal,
    clutch:          drv.clutch_signal,
    brake:           drv.brake_signal,
    reverse:         drv.reverse_signal,
    turn_left:       drv.turn_left_signal,
    turn_right:      drv.turn_right_signal,
    place_barrier:   drv.place_barrier_signal,
    destroy_barrier: drv.destroy_barrier_signal
  };

  // Previous-cycle copies detect input edges and state changes.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= '0;
      state_q <= POWER_OFF;
    end else begin
      in_q    <= in_now;
      state_q <= state;
    end
  end

  hold_counter #(.CNT_W(CNT_W), .TARGET(IDLE_TIMEOUT_CYC)) u_idle (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en      ((state == POWER_ON) || (state == NOT_STARTING) || (state == STARTING)),
    .clr     ((in_now != in_q) || (state != state_q)),
    .done    (idle_done)
  );
`else
  assign idle_done = 1'b0;
`endif

  // Next state, latched direction and next command byte.
  always_comb begin
    next_state = state;
    dir_next   = dir_rev;
    cmd_next   = {CMD_HDR, 6'b0};

    case (state)
      POWER_OFF: begin
        if (hold_done) next_state = POWER_ON;
      end
      POWER_ON: begin
        if (drv.manual_driving_signal) next_state = NOT_STARTING;
      end
      NOT_STARTING: begin
        if (drv.throttle_signal && drv.clutch_signal)       next_state = STARTING;
        else if (drv.throttle_signal && !drv.clutch_signal) next_state = POWER_OFF;
      end
      STARTING: begin
        if (drv.throttle_signal && !drv.clutch_signal && !drv.brake_signal) begin
          next_state = MOVING;
          dir_next   = drv.reverse_signal;
        end
      end
      MOVING: begin
        if ((drv.reverse_signal != dir_rev) && !drv.clutch_signal)
          next_state = POWER_OFF;
        else if (drv.brake_signal || drv.clutch_signal || !drv.throttle_signal)
          next_state = STARTING;
      end
      default: next_state = POWER_OFF;
    endcase

    if ((state != POWER_OFF) && (drv.power_off_signal || idle_done))
      next_state = POWER_OFF;

    if (next_state == MOVING) begin
      cmd_next[FWD]     = ~dir_next;
      cmd_next[BWD]     = dir_next;
      cmd_next[LEFT]    = drv.turn_left_signal & ~drv.turn_right_signal;
      cmd_next[RIGHT]   = drv.turn_right_signal & ~drv.turn_left_signal;
      cmd_next[PLACE]   = drv.place_barrier_signal;
      cmd_next[DESTROY] = drv.destroy_barrier_signal;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= POWER_OFF;
      dir_rev       <= 1'b0;
      drv.cmd_byte  <= {CMD_HDR, 6'b0};
      drv.state_led <= POWER_OFF;
    end else begin
      state         <= next_state;
      dir_rev       <= dir_next;
      drv.cmd_byte  <= cmd_next;
      drv.state_led <= next_state;
    end
  end

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Directed bench for manual_drive_ctrl with a scoreboard of expected {state_led, cmd_byte}.
module tb_manual_drive_ctrl;

  typedef struct {
    string      tag;
    logic [3:0] led;
    logic [7:0] cmd;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  manual_drive_ctrl_if drv ();

  manual_drive_ctrl #(
    .POWER_ON_HOLD_CYC (10),
    .IDLE_TIMEOUT_CYC  (20),
    .CNT_W             (32)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .drv     (drv)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [3:0] led, input logic [7:0] cmd);
    checks++;
    assert ({drv.state_led, drv.cmd_byte} === {led, cmd}) else begin
      errors++;
      $error("FAIL %s: got led=%0h cmd=%02h, expected led=%0h cmd=%02h",
             tag, drv.state_led, drv.cmd_byte, led, cmd);
    end
  endtask

  // Push expectation, clock once, pop and compare just after the edge.
  task automatic step(input string tag, input logic [3:0] led, input logic [7:0] cmd);
    exp_t e;
    e.tag = tag; e.led = led; e.cmd = cmd;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, e.led, e.cmd);
    @(negedge sys_clk);
  endtask

  task automatic clr_in();
    drv.power_on_signal        = 1'b0;
    drv.power_off_signal       = 1'b0;
    drv.manual_driving_signal  = 1'b0;
    drv.throttle_signal        = 1'b0;
    drv.clutch_signal          = 1'b0;
    drv.brake_signal           = 1'b0;
    drv.reverse_signal         = 1'b0;
    drv.turn_left_signal       = 1'b0;
    drv.turn_right_signal      = 1'b0;
    drv.place_barrier_signal   = 1'b0;
    drv.destroy_barrier_signal = 1'b0;
  endtask

  // Hold power_on for exactly 10 cycles: POWER_OFF for 9, POWER_ON on the 10th.
  task automatic hold_on(input string tag);
    drv.power_on_signal = 1'b1;
    for (int i = 0; i < 9; i++) step(tag, 4'h0, 8'h80);
    step(tag, 4'h1, 8'h80);
    drv.power_on_signal = 1'b0;
  endtask

  task automatic to_moving(input string tag);
    hold_on(tag);
    drv.manual_driving_signal = 1'b1;
    step(tag, 4'h2, 8'h80);
    drv.manual_driving_signal = 1'b0;
    drv.throttle_signal = 1'b1;
    drv.clutch_signal   = 1'b1;
    step(tag, 4'h3, 8'h80);
    drv.clutch_signal   = 1'b0;
    step(tag, 4'h4, 8'h81);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    clr_in();
    #12;
    chk("reset", 4'h0, 8'h80);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Power-on hold: 9 cycles is too short, 10 is enough.
    drv.power_on_signal = 1'b1;
    for (int i = 0; i < 9; i++) step("t1_short", 4'h0, 8'h80);
    drv.power_on_signal = 1'b0;
    step("t1_drop", 4'h0, 8'h80);
    hold_on("t1_hold");
    step("t1_stay_on", 4'h1, 8'h80);

    // Start, move, turn, brake, barriers.
    drv.manual_driving_signal = 1'b1;
    step("t2_manual", 4'h2, 8'h80);
    drv.manual_driving_signal = 1'b0;
    drv.throttle_signal = 1'b1;
    drv.clutch_signal   = 1'b1;
    step("t2_start", 4'h3, 8'h80);
    drv.clutch_signal = 1'b0;
    step("t2_move", 4'h4, 8'h81);
    drv.turn_left_signal = 1'b1;
    step("t2_left", 4'h4, 8'h85);
    drv.brake_signal = 1'b1;
    step("t2_brake", 4'h3, 8'h80);
    drv.brake_signal = 1'b0;
    step("t2_remove", 4'h4, 8'h85);
    drv.turn_right_signal = 1'b1;
    step("t2_lr_both", 4'h4, 8'h81);
    drv.turn_left_signal       = 1'b0;
    drv.turn_right_signal      = 1'b0;
    drv.place_barrier_signal   = 1'b1;
    drv.destroy_barrier_signal = 1'b1;
    step("t2_barrier", 4'h4, 8'hB1);
    drv.place_barrier_signal   = 1'b0;
    drv.destroy_barrier_signal = 1'b0;
    drv.throttle_signal        = 1'b0;
    step("t2_lift", 4'h3, 8'h80);

    // Reverse entry; gear change with clutch is safe, without clutch grinds.
    drv.throttle_signal = 1'b1;
    drv.reverse_signal  = 1'b1;
    step("t4_rev_move", 4'h4, 8'h82);
    drv.reverse_signal = 1'b0;
    drv.clutch_signal  = 1'b1;
    step("t4_rev_clutch", 4'h3, 8'h80);
    drv.clutch_signal  = 1'b0;
    drv.reverse_signal = 1'b1;
    step("t4_rev_again", 4'h4, 8'h82);
    drv.reverse_signal = 1'b0;
    step("t4_grind", 4'h0, 8'h80);
    clr_in();

    // Stall in NOT_STARTING.
    hold_on("t3_hold");
    drv.manual_driving_signal = 1'b1;
    step("t3_manual", 4'h2, 8'h80);
    drv.manual_driving_signal = 1'b0;
    drv.throttle_signal = 1'b1;
    step("t3_stall", 4'h0, 8'h80);
    clr_in();

    // Power-off request.
    hold_on("poff_hold");
    drv.power_off_signal = 1'b1;
    step("poff", 4'h0, 8'h80);
    clr_in();

    // Asynchronous reset while moving, then a fresh hold.
    to_moving("t5_move");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rst", 4'h0, 8'h80);
    @(negedge sys_clk);
    rst_n = 1'b1;
    clr_in();
    hold_on("t5_rehold");

`ifdef IDLE_TIMEOUT_EN
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge sys_clk);
      #1;
      if (drv.state_led == 4'h0) begin
        n = i;
        break;
      end
    end
    checks++;
    assert (n >= 20 && n <= 22) else begin
      errors++;
      $error("FAIL t6_idle: timeout after %0d cycles, expected 20..22", n);
    end
    chk("t6_idle_state", 4'h0, 8'h80);
`else
    n = 0;
    for (int i = 0; i < 30; i++) step("t6_no_idle", 4'h1, 8'h80);
`endif

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_empty: got %0d pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
